reg_file_sb: RTL and testbench

Parametrised multi-read-port register file with an integrated hazard scoreboard and a self-clearing initialisation sequencer. It is the next generation of the core's integer register file and sits between decode (read/issue) and writeback in the pipelined RV32I datapath. Register 0 is hardwired to zero. Per-register busy bits let decode detect read-after-write hazards without a separate scoreboard block.

---
 rtl/reg_file_sb_pkg.sv | 15 +
 rtl/reg_file_sb_if.sv | 32 +++
 rtl/reg_file_sb_read_port.sv | 42 ++++
 rtl/reg_file_sb.sv | 95 +++++++++
 tb/tb_reg_file_sb.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared types and default sizes for the reg_file_sb register file.
// The build macro REG_FILE_BYPASS_EN enables write-to-read forwarding in rf_read_port.
package rf_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  localparam int RF_XLEN     = 32;
  localparam int RF_NREGS    = 32;
  localparam int RF_NRD      = 2;
  localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of reg_file_sb: writeback, issue and packed multi-port reads.
// The master side is the pipeline; the slave side is the register file.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = RF_NRD
);
  localparam int AW = $clog2(NREGS);

  logic                  reg_write;
  logic [AW-1:0]         rd;
  logic [XLEN-1:0]       write_data;
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic [NRD*AW-1:0]     rs_addr;
  logic [NRD*XLEN-1:0]   rs_data;
  logic [NRD-1:0]        rs_busy;
  logic                  ready;

  modport master (
    output reg_write, rd, write_data, issue_valid, issue_rd, rs_addr,
    input  rs_data, rs_busy, ready
  );

  modport slave (
    input  reg_write, rd, write_data, issue_valid, issue_rd, rs_addr,
    output rs_data, rs_busy, ready
  );

endinterface

// File: rtl/reg_file_sb_read_port.sv
// One read port: register mux, busy lookup, optional forwarding, not-ready masking.
// With REG_FILE_BYPASS_EN defined, a same-cycle write to the addressed register is forwarded.
module rf_read_port
  import rf_pkg::*;
#(
  parameter  int XLEN  = RF_XLEN,
  parameter  int NREGS = RF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  ready,
  input  logic [AW-1:0]         addr,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  input  logic [NREGS-1:0]      busy_vec,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic [XLEN-1:0]       rd_data,
  output logic                  rd_busy
);

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (ready && addr != AW'(RF_ZERO_REG)) begin
      rd_data = regs_flat[addr*XLEN +: XLEN];
      rd_busy = busy_vec[addr];
`ifdef REG_FILE_BYPASS_EN
      // A producer writing back this cycle has, by definition, completed.
      if (wr_en && wr_addr == addr) begin
        rd_data = wr_data;
        rd_busy = 1'b0;
      end
`endif
    end
  end

`ifndef REG_FILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data};
`endif

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with per-register busy scoreboard and a zeroing init sequencer.
// Define REG_FILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int XLEN  = RF_XLEN,
  parameter  int NREGS = RF_NREGS,
  parameter  int NRD   = RF_NRD,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           reset,
  reg_file_sb_if.slave   bus
);

  rf_state_t                    state_q, state_d;
  logic [AW-1:0]                init_cnt_q, init_cnt_d;
  logic [NREGS-1:0][XLEN-1:0]   regs_q, regs_d;
  logic [NREGS-1:0]             busy_q, busy_d;
  logic                         ready_q, ready_d;
  logic [NREGS*XLEN-1:0]        regs_flat;
  logic                         wr_en;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    regs_d     = regs_q;
    busy_d     = busy_q;
    unique case (state_q)
      RF_INIT: begin
        regs_d[init_cnt_q] = '0;
        init_cnt_d         = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(NREGS - 1)) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        if (bus.reg_write) begin
          if (bus.rd != AW'(RF_ZERO_REG)) begin
            regs_d[bus.rd] = bus.write_data;
          end
          busy_d[bus.rd] = 1'b0;
        end
        // Issue is applied after writeback so a new producer keeps the bit set.
        if (bus.issue_valid && bus.issue_rd != AW'(RF_ZERO_REG)) begin
          busy_d[bus.issue_rd] = 1'b1;
        end
      end
      default: state_d = RF_INIT;
    endcase
    busy_d[RF_ZERO_REG] = 1'b0;
    ready_d = (state_d == RF_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RF_INIT;
      init_cnt_q <= '0;
      busy_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  // Contents need no reset: the INIT sweep zeroes every entry before reads unmask.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign regs_flat = regs_q;
  assign wr_en     = ready_q & bus.reg_write;
  assign bus.ready = ready_q;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    rf_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_port (
      .ready     (ready_q),
      .addr      (bus.rs_addr[k*AW +: AW]),
      .regs_flat (regs_flat),
      .busy_vec  (busy_q),
      .wr_en     (wr_en),
      .wr_addr   (bus.rd),
      .wr_data   (bus.write_data),
      .rd_data   (bus.rs_data[k*XLEN +: XLEN]),
      .rd_busy   (bus.rs_busy[k])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic vs. a behavioural model.
// Follows REG_FILE_BYPASS_EN so the same bench covers both builds.
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk;
  logic reset;

  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  bit chk_en     = 1'b0;

  logic [XLEN-1:0] model_regs [NREGS];
  bit              model_busy [NREGS];
  bit              model_ready = 1'b0;
  int              init_edges  = 0;

  task automatic check_val(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view: after NREGS clean edges the file is all-zero and live.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_ready = 1'b0;
      init_edges  = 0;
      for (int i = 0; i < NREGS; i++) model_busy[i] = 1'b0;
    end else if (!model_ready) begin
      init_edges++;
      if (init_edges == NREGS) begin
        model_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
      end
    end else begin
      if (bus.reg_write) begin
        if (bus.rd != 0) model_regs[bus.rd] = bus.write_data;
        model_busy[bus.rd] = 1'b0;
      end
      if (bus.issue_valid && bus.issue_rd != 0) model_busy[bus.issue_rd] = 1'b1;
    end
  end

  function automatic void expect_port(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (model_ready && a != 0) begin
      d = model_regs[a];
      b = model_busy[a];
`ifdef REG_FILE_BYPASS_EN
      if (bus.reg_write && bus.rd == a) begin
        d = bus.write_data;
        b = 1'b0;
      end
`endif
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [XLEN-1:0] ed;
      logic            eb;
      check_val("ready", XLEN'(bus.ready), XLEN'(model_ready));
      for (int k = 0; k < NRD; k++) begin
        expect_port(bus.rs_addr[k*AW +: AW], ed, eb);
        check_val($sformatf("port%0d_data", k), bus.rs_data[k*XLEN +: XLEN], ed);
        check_val($sformatf("port%0d_busy", k), XLEN'(bus.rs_busy[k]), XLEN'(eb));
      end
    end
  end

  task automatic apply_stimulus(input logic wr, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                                input logic iv, input logic [AW-1:0] ia,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    @(posedge clk);
    #1;
    bus.reg_write   = wr;
    bus.rd          = wa;
    bus.write_data  = wd;
    bus.issue_valid = iv;
    bus.issue_rd    = ia;
    bus.rs_addr     = {a1, a0};
  endtask

  task automatic set_idle();
    bus.reg_write   = 1'b0;
    bus.rd          = '0;
    bus.write_data  = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    while (!bus.ready && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    int edges;
    reset = 1'b1;
    set_idle();
    bus.rs_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check_val("reset_ready", XLEN'(bus.ready), 32'd0);
    check_val("reset_data0", bus.rs_data[XLEN-1:0], 32'd0);
    reset = 1'b0;
    wait_ready(edges);
    check_val("init_latency", XLEN'(edges), 32'd32);

    for (int r = 0; r < NREGS; r++) begin
      apply_stimulus(0, 0, 0, 0, 0, AW'(r), AW'(r));
      @(negedge clk);
      check_val("init_zero_p0", bus.rs_data[XLEN-1:0], 32'd0);
      check_val("init_zero_p1", bus.rs_data[2*XLEN-1:XLEN], 32'd0);
    end

    apply_stimulus(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    apply_stimulus(0, 0, 0, 0, 0, 5, 0);
    @(negedge clk);
    check_val("x5_read", bus.rs_data[XLEN-1:0], 32'hDEADBEEF);
    check_val("x0_read", bus.rs_data[2*XLEN-1:XLEN], 32'd0);
    apply_stimulus(1, 0, 32'h1234, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 5);
    @(negedge clk);
    check_val("x0_write_dropped", bus.rs_data[XLEN-1:0], 32'd0);

    apply_stimulus(0, 0, 0, 1, 7, 7, 7);
    apply_stimulus(0, 0, 0, 0, 0, 7, 7);
    @(negedge clk);
    check_val("x7_busy_set", XLEN'(bus.rs_busy[0]), 32'd1);
    apply_stimulus(1, 7, 32'h55, 0, 0, 7, 7);
    apply_stimulus(0, 0, 0, 1, 0, 7, 0);
    @(negedge clk);
    check_val("x7_busy_clr", XLEN'(bus.rs_busy[0]), 32'd0);
    check_val("x7_data", bus.rs_data[XLEN-1:0], 32'h55);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("x0_never_busy", XLEN'(bus.rs_busy[0]), 32'd0);

    apply_stimulus(1, 9, 32'hAA, 1, 9, 9, 9);
    apply_stimulus(0, 0, 0, 0, 0, 9, 9);
    @(negedge clk);
    check_val("x9_data", bus.rs_data[XLEN-1:0], 32'hAA);
    check_val("x9_set_wins", XLEN'(bus.rs_busy[1]), 32'd1);

    apply_stimulus(1, 3, 32'h11, 0, 0, 3, 3);
    apply_stimulus(1, 3, 32'h77, 0, 0, 3, 3);
    @(negedge clk);
`ifdef REG_FILE_BYPASS_EN
    check_val("bypass_same_cycle", bus.rs_data[XLEN-1:0], 32'h77);
`else
    check_val("no_bypass_old", bus.rs_data[XLEN-1:0], 32'h11);
`endif
    apply_stimulus(0, 0, 0, 0, 0, 3, 3);
    @(negedge clk);
    check_val("x3_next_cycle", bus.rs_data[XLEN-1:0], 32'h77);

    apply_stimulus(1, 4, 32'h99, 0, 0, 4, 4);
    apply_stimulus(0, 0, 0, 1, 4, 4, 4);
    apply_stimulus(0, 0, 0, 0, 0, 4, 4);
    @(negedge clk);
    check_val("x4_busy_pre", XLEN'(bus.rs_busy[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrun_ready", XLEN'(bus.ready), 32'd0);
    check_val("midrun_busy", XLEN'(bus.rs_busy[0]), 32'd0);
    check_val("midrun_data", bus.rs_data[XLEN-1:0], 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.reg_write   = 1'b1;
    bus.rd          = 4;
    bus.write_data  = 32'hFFFF;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 4;
    wait_ready(edges);
    set_idle();
    check_val("reinit_latency", XLEN'(edges), 32'd32);
    apply_stimulus(0, 0, 0, 0, 0, 4, 4);
    @(negedge clk);
    check_val("x4_after_reinit", bus.rs_data[XLEN-1:0], 32'd0);
    check_val("x4_busy_after_reinit", XLEN'(bus.rs_busy[0]), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      apply_stimulus(logic'($urandom_range(0, 1)), rand_addr(), $urandom(),
                     logic'($urandom_range(0, 2) == 0), rand_addr(), rand_addr(), rand_addr());
    end
    @(posedge clk);
    #1;
    set_idle();
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
